// File: rtl/lfsr_rng_arbiter_pkg.sv
// rtl/lfsr_rng_arbiter_pkg.sv - shared types and constants for the LFSR RNG arbiter
// Holds the FSM state encoding, the reset seed, the LFSR tap mask and the
// next-state helper used by the LFSR core.
package lfsr_rng_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    localparam logic [3:0] SEED_DEFAULT_C = 4'b1000;

    // x^4 + x^3 + 1: feedback is the XOR of bits 3 and 2.
    localparam logic [3:0] LFSR_TAPS = 4'b1100;

    function automatic logic [3:0] lfsr_next(input logic [3:0] cur);
        return {cur[2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_rng_arbiter_lfsr4_core.sv
// rtl/lfsr_rng_arbiter_lfsr4_core.sv - 4-bit maximal-length LFSR with load and step
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset, q returns to SEED_DEFAULT
//   load     load load_val into q (wins over step)
//   load_val value to load; the caller guarantees it is nonzero
//   step     advance the LFSR by one state
//   q        current LFSR state
module lfsr4_core
    import lfsr_rng_arbiter_pkg::*;
#(
    parameter logic [3:0] SEED_DEFAULT = SEED_DEFAULT_C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       step,
    output logic [3:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED_DEFAULT;
        end else if (load) begin
            q <= load_val;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// rtl/lfsr_rng_arbiter.sv - round-robin arbiter sharing one 4-bit LFSR among requesters
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset; aborts any transaction in flight
//   req       per-requester request levels, held until the matching gnt pulse
//   seed_we   seed load strobe, accepted only in IDLE (wins over req)
//   seed_in   seed value; zero is replaced by SEED_DEFAULT and flags seed_err
//   gnt       one-hot grant, single-cycle, coincident with rvalid
//   rdata     random word, nonzero only while rvalid is high
//   rvalid    single-cycle data-valid pulse
//   busy      high while shifting or granting
//   seed_err  sticky: the last accepted seed load was zero
module lfsr_rng_arbiter
    import lfsr_rng_arbiter_pkg::*;
#(
    parameter int         WIDTH        = 4,
    parameter int         NREQ         = 2,
    parameter logic [3:0] SEED_DEFAULT = SEED_DEFAULT_C
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             seed_we,
    input  logic [WIDTH-1:0] seed_in,
    output logic [NREQ-1:0]  gnt,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             busy,
    output logic             seed_err
);

    localparam int PW = (NREQ > 2) ? 2 : 1;
    localparam int CW = $clog2(WIDTH);

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic [PW-1:0]   pick;
    logic [CW-1:0]   cnt;
    logic [3:0]      q;
    logic            lfsr_load;
    logic            lfsr_step;
    logic [3:0]      load_val;

    assign lfsr_load = (state == ST_IDLE) && seed_we;
    assign lfsr_step = (state == ST_SHIFT);
    assign load_val  = (seed_in == '0) ? SEED_DEFAULT : seed_in;
    assign busy      = (state == ST_SHIFT) || (state == ST_GRANT);

    lfsr4_core #(
        .SEED_DEFAULT(SEED_DEFAULT)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (lfsr_load),
        .load_val (load_val),
        .step     (lfsr_step),
        .q        (q)
    );

    // Scan requesters starting at the pointer; the first asserted one wins.
    always_comb begin
        logic found;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[(int'(ptr) + i) % NREQ]) begin
                found = 1'b1;
                pick  = PW'((int'(ptr) + i) % NREQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!seed_we && (req != '0)) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs: the GRANT cycle launches gnt/rvalid/rdata so they
    // appear together in the following IDLE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            win      <= '0;
            ptr      <= '0;
            gnt      <= '0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            seed_err <= 1'b0;
        end else begin
            gnt    <= '0;
            rvalid <= 1'b0;
            rdata  <= '0;
            case (state)
                ST_IDLE: begin
                    if (seed_we) begin
                        seed_err <= (seed_in == '0);
                    end else if (req != '0) begin
                        win <= pick;
                        cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    cnt <= cnt + 1'b1;
                end
                ST_GRANT: begin
                    gnt    <= NREQ'(1) << win;
                    rvalid <= 1'b1;
                    rdata  <= q;
                    ptr    <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// tb/tb_lfsr_rng_arbiter.sv - self-checking bench for lfsr_rng_arbiter
module tb_lfsr_rng_arbiter;

    localparam int NREQ = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic            seed_we;
    logic [3:0]      seed_in;
    logic [NREQ-1:0] gnt;
    logic [3:0]      rdata;
    logic            rvalid;
    logic            busy;
    logic            seed_err;

    int n_checks = 0;
    int n_err    = 0;

    // Transaction-level reference state.
    int m_q, m_ptr, m_left, m_win, m_word;
    int m_gnt, m_rdata;
    bit m_rvalid, m_serr;

    lfsr_rng_arbiter #(
        .WIDTH(4),
        .NREQ(NREQ),
        .SEED_DEFAULT(4'b1000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .seed_we  (seed_we),
        .seed_in  (seed_in),
        .gnt      (gnt),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .busy     (busy),
        .seed_err (seed_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int mstep(input int v);
        return ((v << 1) & 15) | (((v >> 3) ^ (v >> 2)) & 1);
    endfunction

    // One rising edge of the reference: a granted request costs 5 busy
    // cycles and its word appears on the edge that ends them.
    task automatic model_edge();
        if (rst) begin
            m_q = 8; m_ptr = 0; m_left = 0; m_win = 0;
            m_rvalid = 0; m_gnt = 0; m_rdata = 0; m_serr = 0;
        end else begin
            m_rvalid = 0; m_gnt = 0; m_rdata = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_rvalid = 1;
                    m_gnt    = 1 << m_win;
                    m_rdata  = m_word;
                    m_ptr    = (m_win + 1) % NREQ;
                end
            end else if (seed_we) begin
                m_q    = (seed_in == 0) ? 8 : int'(seed_in);
                m_serr = (seed_in == 0);
            end else if (req != 0) begin
                for (int i = NREQ - 1; i >= 0; i--) begin
                    if (req[(m_ptr + i) % NREQ]) m_win = (m_ptr + i) % NREQ;
                end
                for (int s = 0; s < 4; s++) m_q = mstep(m_q);
                m_word = m_q;
                m_left = 5;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("rvalid", {31'b0, rvalid}, {31'b0, m_rvalid});
        check("gnt", {30'b0, gnt}, m_gnt);
        check("busy", {31'b0, busy}, {31'b0, (m_left > 0)});
        check("seed_err", {31'b0, seed_err}, {31'b0, m_serr});
        if (m_rvalid) check("rdata", {28'b0, rdata}, m_rdata);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic run_until_valid(input int maxc, output int n, output logic [3:0] w,
                                   output logic [NREQ-1:0] g);
        n = 0; w = '0; g = '0;
        repeat (maxc) begin
            cycle();
            n++;
            if (rvalid) begin
                w = rdata;
                g = gnt;
                return;
            end
        end
        check("timeout", {31'b0, rvalid}, 1);
    endtask

    initial begin
        int n, nv, distinct;
        logic [3:0] w;
        logic [NREQ-1:0] g;
        logic [3:0] words [16];
        bit seen [16];

        rst = 1'b1; req = '0; seed_we = 1'b0; seed_in = '0;
        do_reset();
        check("reset_rdata", {28'b0, rdata}, 0);
        check("reset_busy", {31'b0, busy}, 0);

        // Single requester after reset.
        req = 2'b01;
        run_until_valid(12, n, w, g);
        req = '0;
        check("t1_word", {28'b0, w}, 9);
        check("t1_gnt", {30'b0, g}, 1);
        check("t1_latency", n, 6);
        cycle();

        // Both requesters held: alternating grants, 6 cycles apart.
        do_reset();
        req = 2'b11;
        run_until_valid(12, n, w, g);
        check("rr1_gnt", {30'b0, g}, 1);
        check("rr1_word", {28'b0, w}, 9);
        run_until_valid(12, n, w, g);
        check("rr2_gnt", {30'b0, g}, 2);
        check("rr2_word", {28'b0, w}, 4'hA);
        check("rr2_spacing", n, 6);
        run_until_valid(12, n, w, g);
        check("rr3_gnt", {30'b0, g}, 1);
        req = '0;
        cycle();

        // Nonzero seed.
        do_reset();
        seed_we = 1'b1; seed_in = 4'h1;
        cycle();
        seed_we = 1'b0;
        req = 2'b01;
        run_until_valid(12, n, w, g);
        req = '0;
        check("seed1_word", {28'b0, w}, 3);
        check("seed1_err", {31'b0, seed_err}, 0);
        cycle();

        // Zero seed substitutes the default and sets the sticky flag.
        seed_we = 1'b1; seed_in = 4'h0;
        cycle();
        seed_we = 1'b0;
        check("zseed_err", {31'b0, seed_err}, 1);
        req = 2'b01;
        run_until_valid(12, n, w, g);
        req = '0;
        check("zseed_word", {28'b0, w}, 9);
        check("zseed_err_hold", {31'b0, seed_err}, 1);
        cycle();
        seed_we = 1'b1; seed_in = 4'h5;
        cycle();
        seed_we = 1'b0;
        check("zseed_clear", {31'b0, seed_err}, 0);

        // Reset in the second SHIFT cycle aborts without rvalid.
        do_reset();
        req = 2'b01;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req = '0;
        check("abort_busy", {31'b0, busy}, 0);
        nv = 0;
        repeat (6) begin
            cycle();
            if (rvalid) nv++;
        end
        check("abort_novalid", nv, 0);
        req = 2'b01;
        run_until_valid(12, n, w, g);
        req = '0;
        check("abort_word", {28'b0, w}, 9);
        cycle();

        // Period: 16 back-to-back words; seed_we while busy is ignored.
        do_reset();
        req = 2'b01;
        for (int k = 0; k < 16; k++) begin
            run_until_valid(16, n, w, g);
            words[k] = w;
            if (k == 2) begin
                cycle();
                seed_we = 1'b1; seed_in = 4'h7;
                cycle();
                seed_we = 1'b0;
            end
        end
        req = '0;
        cycle();
        distinct = 0;
        for (int k = 0; k < 16; k++) seen[k] = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (!seen[words[k]]) distinct++;
            seen[words[k]] = 1'b1;
        end
        check("period_distinct", distinct, 15);
        check("period_first", {28'b0, words[0]}, 9);
        check("period_wrap", {28'b0, words[15]}, {28'b0, words[0]});
        check("period_no_zero", {31'b0, seen[0]}, 0);

        // Randomized requesters, seeds and occasional resets.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst     = ($urandom_range(99) == 0);
            seed_we = ($urandom_range(11) == 0);
            seed_in = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom_range(15));
            cycle();
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(2) == 0) req[i] = 1'b1;
            end
        end
        rst = 1'b0; seed_we = 1'b0; req = '0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
